// File: rtl/led_matrix_pkg.sv
// Shared types and sizes for the 16x16 bi-colour LED matrix (game logic and scan-out).
package led_matrix_pkg;

  localparam int NUM_ROWS = 16;
  localparam int NUM_COLS = 16;
  localparam int ROW_W    = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } scan_state_t;

  // [row][col], row 0 = top of the panel
  typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] pixel_frame_t;

  function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
    return NUM_ROWS'(1) << r;
  endfunction

endpackage

// File: rtl/led_frame_latch.sv
// Shadow copy of the red and green frames; both colours load on the same edge so a
// scanned frame is always a coherent snapshot of the game output.
module led_frame_latch
  import led_matrix_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  pixel_frame_t red_live,
  input  pixel_frame_t grn_live,
  output pixel_frame_t red_shadow,
  output pixel_frame_t grn_shadow
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_shadow <= '0;
      grn_shadow <= '0;
    end else if (load) begin
      red_shadow <= red_live;
      grn_shadow <= grn_live;
    end
  end

endmodule

// File: rtl/led_matrix_scan.sv
// Row-at-a-time scan-out for the 16x16 bi-colour panel, with blanking between rows and a
// per-frame snapshot so game updates never tear a frame in progress.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int DWELL_CYCLES = 8,
  parameter int BLANK_CYCLES = 1,
  parameter bit ROW_ACT_LOW  = 1'b1,
  parameter bit COL_ACT_LOW  = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EnableCount,
  input  pixel_frame_t        RedPixels,
  input  pixel_frame_t        GrnPixels,
  output logic [NUM_ROWS-1:0] RowSel,
  output logic [NUM_COLS-1:0] RedCol,
  output logic [NUM_COLS-1:0] GrnCol,
  output logic                FrameStart
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]    DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(NUM_ROWS - 1);
  localparam logic [NUM_ROWS-1:0] ROW_OFF    = ROW_ACT_LOW ? '1 : '0;
  localparam logic [NUM_COLS-1:0] COL_OFF    = COL_ACT_LOW ? '1 : '0;

  function automatic logic [NUM_ROWS-1:0] row_drive(input logic [ROW_W-1:0] r);
    return ROW_ACT_LOW ? ~row_onehot(r) : row_onehot(r);
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [NUM_COLS-1:0] bits);
    return COL_ACT_LOW ? ~bits : bits;
  endfunction

  scan_state_t      state_p0, state_nxt;
  logic [ROW_W-1:0] row_p0, row_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             snap;
  pixel_frame_t     red_shadow_p0, grn_shadow_p0;

  led_frame_latch u_latch (
    .clk        (CLK),
    .rst_n      (RST),
    .load       (snap),
    .red_live   (RedPixels),
    .grn_live   (GrnPixels),
    .red_shadow (red_shadow_p0),
    .grn_shadow (grn_shadow_p0)
  );

  // stage 0: scan state, row and dwell counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_p0 <= IDLE;
      row_p0   <= '0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      row_p0   <= row_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    row_nxt   = row_p0;
    cnt_nxt   = cnt_p0;
    snap      = 1'b0;
    if (!EnableCount) begin
      state_nxt = IDLE;
      row_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state_p0)
        IDLE: begin
          state_nxt = BLANK;
          row_nxt   = '0;
          cnt_nxt   = '0;
          snap      = 1'b1;
        end
        BLANK: begin
          if (cnt_p0 == BLANK_LAST) begin
            state_nxt = DRIVE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_p0 + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_p0 == DWELL_LAST) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            row_nxt   = row_p0 + 1'b1;
            // wrapping back to row 0 starts a new frame
            snap      = (row_p0 == ROW_LAST);
          end else begin
            cnt_nxt = cnt_p0 + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          row_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // stage 1: registered panel drive, aligned with the state being entered
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RowSel     <= ROW_OFF;
      RedCol     <= COL_OFF;
      GrnCol     <= COL_OFF;
      FrameStart <= 1'b0;
    end else begin
      FrameStart <= snap;
      if (state_nxt == DRIVE) begin
        RowSel <= row_drive(row_nxt);
        RedCol <= col_drive(red_shadow_p0[row_nxt]);
        GrnCol <= col_drive(grn_shadow_p0[row_nxt]);
      end else begin
        RowSel <= ROW_OFF;
        RedCol <= COL_OFF;
        GrnCol <= COL_OFF;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: default and alternate-parameter instances against a
// position-in-frame reference model.
module tb_led_matrix_scan;
  import led_matrix_pkg::*;

  logic         CLK = 1'b0;
  logic         RST;
  logic         enA, enB;
  pixel_frame_t redA, grnA, redB, grnB;
  logic [15:0]  rowA, rcA, gcA, rowB, rcB, gcB;
  logic         fsA, fsB;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int kA = 0, kB = 0;
  pixel_frame_t shRA = '0, shGA = '0, shRB = '0, shGB = '0;

  always #5 CLK = ~CLK;

  led_matrix_scan dut_a (
    .CLK(CLK), .RST(RST), .EnableCount(enA), .RedPixels(redA), .GrnPixels(grnA),
    .RowSel(rowA), .RedCol(rcA), .GrnCol(gcA), .FrameStart(fsA));

  led_matrix_scan #(.DWELL_CYCLES(3), .BLANK_CYCLES(2), .ROW_ACT_LOW(1'b0), .COL_ACT_LOW(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .EnableCount(enB), .RedPixels(redB), .GrnPixels(grnB),
    .RowSel(rowB), .RedCol(rcB), .GrnCol(gcB), .FrameStart(fsB));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_frame(output pixel_frame_t f);
    for (int r = 0; r < 16; r++) f[r] = 16'($urandom);
  endtask

  // k = edges since enable (0 = idle); frame position derived from the cycle arithmetic
  function automatic void model_out(input int k, input int d, input int b, input bit rl, input bit cl,
                                    input pixel_frame_t sr, input pixel_frame_t sg,
                                    output logic [15:0] rs, output logic [15:0] rc,
                                    output logic [15:0] gc, output logic fs);
    int p, q, row, w;
    logic [15:0] oh;
    p  = 16 * (d + b);
    rs = rl ? 16'hFFFF : 16'h0000;
    rc = cl ? 16'hFFFF : 16'h0000;
    gc = rc;
    fs = 1'b0;
    if (k > 0) begin
      q   = (k - 1) % p;
      row = q / (d + b);
      w   = q % (d + b);
      fs  = (q == 0);
      if (w >= b) begin
        oh = 16'h0001 << row;
        rs = rl ? ~oh : oh;
        rc = cl ? ~sr[row] : sr[row];
        gc = cl ? ~sg[row] : sg[row];
      end
    end
  endfunction

  function automatic bit a_lit_row(input int row);
    int q;
    if (kA == 0) return 1'b0;
    q = (kA - 1) % 144;
    return (q / 9 == row) && (q % 9 >= 1);
  endfunction

  task automatic step();
    logic pa, pb;
    pixel_frame_t pra, pga, prb, pgb;
    logic [15:0] ers, erc, egc;
    logic efs;
    pa = enA; pb = enB; pra = redA; pga = grnA; prb = redB; pgb = grnB;
    @(posedge CLK);
    cyc++;
    if (!RST) begin
      kA = 0; kB = 0; shRA = '0; shGA = '0; shRB = '0; shGB = '0;
    end else begin
      if (pa) begin
        kA++;
        if ((kA - 1) % 144 == 0) begin shRA = pra; shGA = pga; end
      end else kA = 0;
      if (pb) begin
        kB++;
        if ((kB - 1) % 80 == 0) begin shRB = prb; shGB = pgb; end
      end else kB = 0;
    end
    #1;
    model_out(kA, 8, 1, 1'b1, 1'b0, shRA, shGA, ers, erc, egc, efs);
    check("A_RowSel", rowA, ers);
    check("A_RedCol", rcA, erc);
    check("A_GrnCol", gcA, egc);
    check("A_FrameStart", fsA, efs);
    check("A_onehot", $onehot0(~rowA), 1);
    model_out(kB, 3, 2, 1'b0, 1'b1, shRB, shGB, ers, erc, egc, efs);
    check("B_RowSel", rowB, ers);
    check("B_RedCol", rcB, erc);
    check("B_GrnCol", gcB, egc);
    check("B_FrameStart", fsB, efs);
    check("B_onehot", $onehot0(rowB), 1);
  endtask

  initial begin
    int c0;
    bit found;

    // 1: reset state, then released with scanning disabled
    RST = 1'b1; enA = 1'b0; enB = 1'b0;
    rand_frame(redA); rand_frame(grnA); rand_frame(redB); rand_frame(grnB);
    #2 RST = 1'b0;
    #1;
    check("rst_RowSelA", rowA, 16'hFFFF);
    check("rst_RedColA", rcA, 16'h0000);
    check("rst_GrnColA", gcA, 16'h0000);
    check("rst_FrameStartA", fsA, 0);
    for (int i = 0; i < 3; i++) begin
      rand_frame(redA); rand_frame(grnA);
      step();
    end
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_frame(redA); rand_frame(grnA); rand_frame(redB);
      step();
    end

    // 2: full scan with a diagonal red pattern
    for (int r = 0; r < 16; r++) redA[r] = 16'h0001 << r;
    grnA = '0;
    enA = 1'b1;
    enB = 1'b1;
    step();
    check("fs_first_cycle", fsA, 1);
    c0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (fsA) found = 1'b1;
    end
    check("frame_period_A", cyc - c0, 144);

    // 3: live frame changes while row 7 is lit
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (a_lit_row(7)) found = 1'b1;
    end
    check("reach_row7", found, 1);
    redA = '1;
    rand_frame(grnA);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (a_lit_row(10)) found = 1'b1;
    end
    check("tear_row10_old", rcA, 16'h0400);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (fsA) found = 1'b1;
    end
    check("tear_next_fs", found, 1);
    step(); step();
    check("tear_row0_new", rcA, 16'hFFFF);

    // 4: disable mid-row 5, then re-enable
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (a_lit_row(5)) found = 1'b1;
    end
    check("reach_row5", found, 1);
    enA = 1'b0;
    step();
    check("dis_RowSel", rowA, 16'hFFFF);
    check("dis_RedCol", rcA, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      rand_frame(redA); rand_frame(grnA);
      step();
    end
    enA = 1'b1;
    step();
    check("reen_fs", fsA, 1);
    step();
    check("reen_row0", rowA, 16'hFFFE);
    for (int i = 0; i < 150; i++) begin
      rand_frame(redA); rand_frame(grnA); rand_frame(redB); rand_frame(grnB);
      step();
    end

    // 5: alternate-parameter instance frame period
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (fsB) found = 1'b1;
    end
    check("B_fs_seen", found, 1);
    c0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      rand_frame(redB); rand_frame(grnB);
      step();
      if (fsB) found = 1'b1;
    end
    check("frame_period_B", cyc - c0, 80);
    enB = 1'b0;
    step(); step();
    enB = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_frame(redB);
      step();
    end

    // 6: asynchronous reset while a row is lit
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (a_lit_row(int'(((kA - 1) % 144) / 9))) found = 1'b1;
    end
    check("reach_drive", found, 1);
    #2 RST = 1'b0;
    #1;
    check("arst_RowSelA", rowA, 16'hFFFF);
    check("arst_RedColA", rcA, 16'h0000);
    check("arst_GrnColA", gcA, 16'h0000);
    check("arst_FrameStartA", fsA, 0);
    check("arst_RowSelB", rowB, 16'h0000);
    check("arst_RedColB", rcB, 16'hFFFF);
    kA = 0; kB = 0; shRA = '0; shGA = '0; shRB = '0; shGB = '0;
    step(); step();
    RST = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_frame(redA); rand_frame(grnA);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
